// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared opcodes, FSM states and control-word encodings for the
//               8-bit CPU control unit.
// Revision    : 1.0
// ============================================================================
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_FETCH_L = 3'd1,
        ST_FETCH_H = 3'd2,
        ST_EXEC1   = 3'd3,
        ST_EXEC2   = 3'd4,
        ST_HALT    = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        OP_LDI  = 4'h0, OP_LDM = 4'h1, OP_STM = 4'h2, OP_MOV = 4'h3,
        OP_ADD  = 4'h4, OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7,
        OP_XOR  = 4'h8, OP_INC = 4'h9, OP_DEC = 4'hA, OP_BRA = 4'hB,
        OP_BEQ  = 4'hC, OP_BNE = 4'hD, OP_NOP = 4'hE, OP_HALT = 4'hF
    } opcode_t;

    localparam logic [1:0] c_FUN_CLR  = 2'b00;
    localparam logic [1:0] c_FUN_LOAD = 2'b01;
    localparam logic [1:0] c_FUN_DEC  = 2'b10;
    localparam logic [1:0] c_FUN_INC  = 2'b11;

    localparam logic [3:0] c_ALU_A   = 4'd0;
    localparam logic [3:0] c_ALU_B   = 4'd1;
    localparam logic [3:0] c_ALU_ADD = 4'd4;
    localparam logic [3:0] c_ALU_SUB = 4'd5;
    localparam logic [3:0] c_ALU_AND = 4'd7;
    localparam logic [3:0] c_ALU_OR  = 4'd8;
    localparam logic [3:0] c_ALU_XOR = 4'd10;

    localparam logic [1:0] c_MUX_ALU  = 2'd0;
    localparam logic [1:0] c_MUX_MEM  = 2'd1;
    localparam logic [1:0] c_MUX_IMM  = 2'd2;
    localparam logic [1:0] c_MUX_ARFC = 2'd3;

    localparam logic [1:0] c_ARF_SEL_AR = 2'd0;
    localparam logic [1:0] c_ARF_SEL_PC = 2'd3;

    localparam logic [3:0] c_ARF_EN_PC  = 4'b1000;
    localparam logic [3:0] c_ARF_EN_AR  = 4'b0100;
    localparam logic [3:0] c_EN_ALL     = 4'b1111;

    localparam int c_FLAG_Z = 3;

    typedef struct packed {
        logic [2:0] rf_outa_sel;
        logic [2:0] rf_outb_sel;
        logic [1:0] rf_fun_sel;
        logic [3:0] rf_rsel;
        logic [3:0] rf_tsel;
        logic [3:0] alu_fun_sel;
        logic [1:0] arf_outc_sel;
        logic [1:0] arf_outd_sel;
        logic [1:0] arf_fun_sel;
        logic [3:0] arf_reg_sel;
        logic       ir_lh;
        logic       ir_enable;
        logic [1:0] ir_funsel;
        logic       mem_wr;
        logic       mem_cs;
        logic [1:0] mux_a_sel;
        logic [1:0] mux_b_sel;
        logic       mux_c_sel;
        logic       halted;
        logic       flag_we;
    } ctrl_t;

    localparam int c_CTRL_W = $bits(ctrl_t);

    // C-port stays parked on PC and memory addresses default to PC.
    localparam ctrl_t c_CTRL_IDLE = '{
        rf_outa_sel:  3'd0,  rf_outb_sel: 3'd0,  rf_fun_sel:  2'd0,
        rf_rsel:      4'd0,  rf_tsel:     4'd0,  alu_fun_sel: 4'd0,
        arf_outc_sel: c_ARF_SEL_PC, arf_outd_sel: c_ARF_SEL_PC,
        arf_fun_sel:  2'd0,  arf_reg_sel: 4'd0,  ir_lh:       1'b0,
        ir_enable:    1'b0,  ir_funsel:   2'd0,  mem_wr:      1'b0,
        mem_cs:       1'b1,  mux_a_sel:   2'd0,  mux_b_sel:   2'd0,
        mux_c_sel:    1'b0,  halted:      1'b0,  flag_we:     1'b0
    };

    function automatic logic [2:0] rf_port(input logic [1:0] r);
        return {1'b1, r};
    endfunction

    function automatic logic [3:0] rf_onehot(input logic [1:0] r);
        return 4'b1000 >> r;
    endfunction

    function automatic logic [3:0] alu_code(input opcode_t op);
        case (op)
            OP_ADD:  return c_ALU_ADD;
            OP_SUB:  return c_ALU_SUB;
            OP_AND:  return c_ALU_AND;
            OP_OR:   return c_ALU_OR;
            OP_XOR:  return c_ALU_XOR;
            default: return c_ALU_A;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/cu_decode.sv
`default_nettype none
// ============================================================================
// Module      : cu_decode
// Description : Combinational state/opcode to control-word decode.
// Revision    : 1.0
// ============================================================================
module cu_decode
    import cpu_pkg::*;
(
    input  logic [2:0]          state_i,
    input  logic [7:0]          ir_hi_i,
    input  logic                flag_z_i,
    output logic [c_CTRL_W-1:0] ctrl_o
);

    state_t     w_state;
    opcode_t    w_op;
    logic [1:0] w_rd;
    logic [1:0] w_rs;
    logic       w_take;
    ctrl_t      w_c;

    assign w_state = state_t'(state_i);
    assign w_op    = opcode_t'(ir_hi_i[7:4]);
    assign w_rd    = ir_hi_i[3:2];
    assign w_rs    = ir_hi_i[1:0];
    assign w_take  = (w_op == OP_BRA) || (w_op == OP_BEQ && flag_z_i) ||
                     (w_op == OP_BNE && !flag_z_i);

    always_comb begin
        w_c = c_CTRL_IDLE;
        unique case (w_state)
            ST_INIT: begin
                w_c.rf_fun_sel  = c_FUN_CLR;
                w_c.rf_rsel     = c_EN_ALL;
                w_c.rf_tsel     = c_EN_ALL;
                w_c.arf_fun_sel = c_FUN_CLR;
                w_c.arf_reg_sel = c_EN_ALL;
                w_c.ir_enable   = 1'b1;
                w_c.ir_funsel   = c_FUN_CLR;
            end
            ST_FETCH_L, ST_FETCH_H: begin
                w_c.arf_outd_sel = c_ARF_SEL_PC;
                w_c.mem_cs       = 1'b0;
                w_c.ir_enable    = 1'b1;
                w_c.ir_funsel    = c_FUN_LOAD;
                w_c.ir_lh        = (w_state == ST_FETCH_H);
                w_c.arf_reg_sel  = c_ARF_EN_PC;
                w_c.arf_fun_sel  = c_FUN_INC;
            end
            ST_EXEC1: begin
                unique case (w_op)
                    OP_LDI: begin
                        w_c.mux_a_sel  = c_MUX_IMM;
                        w_c.rf_fun_sel = c_FUN_LOAD;
                        w_c.rf_rsel    = rf_onehot(w_rd);
                    end
                    OP_LDM, OP_STM: begin
                        w_c.mux_b_sel   = c_MUX_IMM;
                        w_c.arf_fun_sel = c_FUN_LOAD;
                        w_c.arf_reg_sel = c_ARF_EN_AR;
                    end
                    OP_MOV: begin
                        w_c.rf_outa_sel = rf_port(w_rs);
                        w_c.alu_fun_sel = c_ALU_A;
                        w_c.mux_a_sel   = c_MUX_ALU;
                        w_c.rf_fun_sel  = c_FUN_LOAD;
                        w_c.rf_rsel     = rf_onehot(w_rd);
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        w_c.rf_outa_sel = rf_port(w_rd);
                        w_c.rf_outb_sel = rf_port(w_rs);
                        w_c.alu_fun_sel = alu_code(w_op);
                        w_c.mux_a_sel   = c_MUX_ALU;
                        w_c.rf_fun_sel  = c_FUN_LOAD;
                        w_c.rf_rsel     = rf_onehot(w_rd);
                        w_c.flag_we     = 1'b1;
                    end
                    OP_INC, OP_DEC: begin
                        w_c.rf_fun_sel = (w_op == OP_INC) ? c_FUN_INC : c_FUN_DEC;
                        w_c.rf_rsel    = rf_onehot(w_rd);
                    end
                    OP_BRA, OP_BEQ, OP_BNE: begin
                        if (w_take) begin
                            w_c.mux_b_sel   = c_MUX_IMM;
                            w_c.arf_fun_sel = c_FUN_LOAD;
                            w_c.arf_reg_sel = c_ARF_EN_PC;
                        end
                    end
                    default: ;
                endcase
            end
            ST_EXEC2: begin
                // Second memory cycle: AR addresses memory for both LDM and STM.
                if (w_op == OP_LDM) begin
                    w_c.arf_outd_sel = c_ARF_SEL_AR;
                    w_c.mem_cs       = 1'b0;
                    w_c.mux_a_sel    = c_MUX_MEM;
                    w_c.rf_fun_sel   = c_FUN_LOAD;
                    w_c.rf_rsel      = rf_onehot(w_rd);
                end else if (w_op == OP_STM) begin
                    w_c.rf_outa_sel  = rf_port(w_rd);
                    w_c.mux_c_sel    = 1'b0;
                    w_c.alu_fun_sel  = c_ALU_A;
                    w_c.arf_outd_sel = c_ARF_SEL_AR;
                    w_c.mem_cs       = 1'b0;
                    w_c.mem_wr       = 1'b1;
                end
            end
            ST_HALT: w_c.halted = 1'b1;
            default: ;
        endcase
    end

    assign ctrl_o = w_c;

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Multi-cycle CPU control FSM with flag register.
// Revision    : 1.0
// ============================================================================
module control_sequencer
    import cpu_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IROut,
    input  logic [3:0]  ALUOutFlag,
    output logic [2:0]  RF_OutASel,
    output logic [2:0]  RF_OutBSel,
    output logic [1:0]  RF_FunSel,
    output logic [3:0]  RF_RSel,
    output logic [3:0]  RF_TSel,
    output logic [3:0]  ALU_FunSel,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [1:0]  ARF_FunSel,
    output logic [3:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Enable,
    output logic [1:0]  IR_Funsel,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic        Halted
);

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    ctrl_t      w_dec;
    ctrl_t      w_ctrl;
    opcode_t    w_op;
    logic       w_unused_imm;

    assign w_op         = opcode_t'(IROut[15:12]);
    assign w_unused_imm = ^IROut[7:0];

    cu_decode u_decode (
        .state_i  (state_q),
        .ir_hi_i  (IROut[15:8]),
        .flag_z_i (flags_q[c_FLAG_Z]),
        .ctrl_o   (w_dec)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_INIT;
            flags_q <= 4'd0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        state_d = state_q;
        flags_d = flags_q;
        unique case (state_q)
            ST_INIT: begin
                flags_d = 4'd0;
                state_d = ST_FETCH_L;
            end
            ST_FETCH_L: state_d = ST_FETCH_H;
            ST_FETCH_H: state_d = ST_EXEC1;
            ST_EXEC1: begin
                if (w_dec.flag_we) begin
                    flags_d = ALUOutFlag;
                end
                if (w_op == OP_HALT) begin
                    state_d = ST_HALT;
                end else if (w_op == OP_LDM || w_op == OP_STM) begin
                    state_d = ST_EXEC2;
                end else begin
                    state_d = ST_FETCH_L;
                end
            end
            ST_EXEC2: state_d = ST_FETCH_L;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_INIT;
        endcase
    end

    // Reset masks the decode so a pending STM write can never reach memory.
    assign w_ctrl = Reset ? c_CTRL_IDLE : w_dec;

    assign RF_OutASel  = w_ctrl.rf_outa_sel;
    assign RF_OutBSel  = w_ctrl.rf_outb_sel;
    assign RF_FunSel   = w_ctrl.rf_fun_sel;
    assign RF_RSel     = w_ctrl.rf_rsel;
    assign RF_TSel     = w_ctrl.rf_tsel;
    assign ALU_FunSel  = w_ctrl.alu_fun_sel;
    assign ARF_OutCSel = w_ctrl.arf_outc_sel;
    assign ARF_OutDSel = w_ctrl.arf_outd_sel;
    assign ARF_FunSel  = w_ctrl.arf_fun_sel;
    assign ARF_RegSel  = w_ctrl.arf_reg_sel;
    assign IR_LH       = w_ctrl.ir_lh;
    assign IR_Enable   = w_ctrl.ir_enable;
    assign IR_Funsel   = w_ctrl.ir_funsel;
    assign Mem_WR      = w_ctrl.mem_wr;
    assign Mem_CS      = w_ctrl.mem_cs;
    assign MuxASel     = w_ctrl.mux_a_sel;
    assign MuxBSel     = w_ctrl.mux_b_sel;
    assign MuxCSel     = w_ctrl.mux_c_sel;
    assign Halted      = w_ctrl.halted;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_control_sequencer
// Description : Datapath environment plus instruction-level reference model.
// Revision    : 1.0
// ============================================================================
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        load_req;
    logic [15:0] IROut;
    logic [3:0]  ALUOutFlag;
    logic [2:0]  RF_OutASel, RF_OutBSel;
    logic [1:0]  RF_FunSel, ARF_OutCSel, ARF_OutDSel, ARF_FunSel, IR_Funsel, MuxASel, MuxBSel;
    logic [3:0]  RF_RSel, RF_TSel, ALU_FunSel, ARF_RegSel;
    logic        IR_LH, IR_Enable, Mem_WR, Mem_CS, MuxCSel, Halted;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clock = ~Clock;

    control_sequencer dut (
        .Clock(Clock), .Reset(Reset), .IROut(IROut), .ALUOutFlag(ALUOutFlag),
        .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
        .RF_RSel(RF_RSel), .RF_TSel(RF_TSel), .ALU_FunSel(ALU_FunSel),
        .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel),
        .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH), .IR_Enable(IR_Enable),
        .IR_Funsel(IR_Funsel), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS),
        .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel), .Halted(Halted)
    );

    // ---------------- datapath driven by the DUT's control word -------------
    logic [7:0]  R [4];
    logic [7:0]  T [4];
    logic [7:0]  PC, AR, SP, PCP;
    logic [15:0] IR;
    logic [7:0]  mem  [256];
    logic [7:0]  prog [256];
    logic [7:0]  rf_a, rf_b, arf_d, mem_out, alu_a, alu_out, mux_a, mux_b;
    logic [11:0] alu_res;

    function automatic logic [11:0] alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] r;
        logic       c, o;
        s = 9'd0; r = 8'd0; c = 1'b0; o = 1'b0;
        case (op)
            4'd0:  r = a;
            4'd1:  r = b;
            4'd4:  begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; o = (a[7] == b[7]) && (r[7] != a[7]); end
            4'd5:  begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = s[8]; o = (a[7] != b[7]) && (r[7] != a[7]); end
            4'd7:  r = a & b;
            4'd8:  r = a | b;
            4'd10: r = a ^ b;
            default: r = 8'd0;
        endcase
        return {r == 8'd0, c, r[7], o, r};
    endfunction

    function automatic logic [7:0] reg_op(input logic [1:0] f, input logic [7:0] cur, input logic [7:0] din);
        case (f)
            2'b00:   return 8'd0;
            2'b01:   return din;
            2'b10:   return cur - 8'd1;
            default: return cur + 8'd1;
        endcase
    endfunction

    always_comb begin
        rf_a = RF_OutASel[2] ? R[RF_OutASel[1:0]] : T[RF_OutASel[1:0]];
        rf_b = RF_OutBSel[2] ? R[RF_OutBSel[1:0]] : T[RF_OutBSel[1:0]];
        case (ARF_OutDSel)
            2'd0:    arf_d = AR;
            2'd1:    arf_d = SP;
            2'd2:    arf_d = PCP;
            default: arf_d = PC;
        endcase
        mem_out = mem[arf_d];
        alu_a   = MuxCSel ? PC : rf_a;
        alu_res = alu(ALU_FunSel, alu_a, rf_b);
        alu_out = alu_res[7:0];
        case (MuxASel)
            2'd0: mux_a = alu_out;  2'd1: mux_a = mem_out;
            2'd2: mux_a = IR[7:0];  default: mux_a = PC;
        endcase
        case (MuxBSel)
            2'd0: mux_b = alu_out;  2'd1: mux_b = mem_out;
            2'd2: mux_b = IR[7:0];  default: mux_b = PC;
        endcase
    end

    assign IROut      = IR;
    assign ALUOutFlag = alu_res[11:8];

    always @(posedge Clock) begin
        if (load_req) begin
            for (int i = 0; i < 256; i++) mem[i] <= prog[i];
        end else if (!Mem_CS && Mem_WR) begin
            mem[arf_d] <= alu_out;
        end
        for (int i = 0; i < 4; i++) begin
            if (RF_RSel[3-i]) R[i] <= reg_op(RF_FunSel, R[i], mux_a);
            if (RF_TSel[3-i]) T[i] <= reg_op(RF_FunSel, T[i], mux_a);
        end
        if (ARF_RegSel[3]) PC  <= reg_op(ARF_FunSel, PC, mux_b);
        if (ARF_RegSel[2]) AR  <= reg_op(ARF_FunSel, AR, mux_b);
        if (ARF_RegSel[1]) SP  <= reg_op(ARF_FunSel, SP, mux_b);
        if (ARF_RegSel[0]) PCP <= reg_op(ARF_FunSel, PCP, mux_b);
        if (IR_Enable) begin
            case (IR_Funsel)
                2'b00: IR <= 16'd0;
                2'b01: if (IR_LH) IR[15:8] <= mem_out; else IR[7:0] <= mem_out;
                2'b10: IR <= IR - 16'd1;
                default: IR <= IR + 16'd1;
            endcase
        end
    end

    // ---------------- instruction-level reference model ---------------------
    logic [7:0] m_r [4];
    logic [7:0] m_mem [256];
    logic [7:0] m_pc, m_ar;
    logic       m_z;

    task automatic model_step(output int cyc, output int wr, output bit h);
        logic [15:0] ins;
        logic [3:0]  op;
        logic [1:0]  rd, rs;
        logic [7:0]  imm, a, b, r;
        ins = {m_mem[m_pc + 8'd1], m_mem[m_pc]};
        m_pc = m_pc + 8'd2;
        op = ins[15:12]; rd = ins[11:10]; rs = ins[9:8]; imm = ins[7:0];
        a = m_r[rd]; b = m_r[rs];
        cyc = 3; wr = 0; h = 1'b0;
        case (op)
            4'h0: m_r[rd] = imm;
            4'h1: begin m_ar = imm; m_r[rd] = m_mem[imm]; cyc = 4; end
            4'h2: begin m_ar = imm; m_mem[imm] = a; cyc = 4; wr = 1; end
            4'h3: m_r[rd] = b;
            4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
                case (op)
                    4'h4: r = a + b;
                    4'h5: r = a - b;
                    4'h6: r = a & b;
                    4'h7: r = a | b;
                    default: r = a ^ b;
                endcase
                m_r[rd] = r;
                m_z = (r == 8'd0);
            end
            4'h9: m_r[rd] = a + 8'd1;
            4'hA: m_r[rd] = a - 8'd1;
            4'hB: m_pc = imm;
            4'hC: if (m_z)  m_pc = imm;
            4'hD: if (!m_z) m_pc = imm;
            4'hF: h = 1'b1;
            default: ;
        endcase
    endtask

    // ---------------- checking and sequencing helpers -----------------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit at_fetch_l();
        return IR_Enable && !IR_LH && !Mem_CS && (IR_Funsel == 2'b01);
    endfunction

    task automatic cycle();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 8'h00;
    endtask

    task automatic put(input int addr, input logic [15:0] w);
        prog[addr]     = w[7:0];
        prog[addr + 1] = w[15:8];
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b1; load_req = 1'b1;
        @(negedge Clock);
        load_req = 1'b0;
        @(negedge Clock);
        chk("rst_cs_idle", Mem_CS, 1);
        chk("rst_wr_idle", Mem_WR, 0);
        chk("rst_en_idle", {RF_RSel, RF_TSel, ARF_RegSel, IR_Enable}, 0);
        chk("rst_dsel_csel", {ARF_OutDSel, ARF_OutCSel}, 4'hF);
        for (int i = 0; i < 256; i++) m_mem[i] = prog[i];
        for (int i = 0; i < 4; i++) m_r[i] = 8'd0;
        m_pc = 8'd0; m_ar = 8'd0; m_z = 1'b0;
        Reset = 1'b0;
        #1;
        chk("init_clear", {RF_RSel, RF_TSel, ARF_RegSel, IR_Enable, IR_Funsel}, {12'hFFF, 1'b1, 2'b00});
    endtask

    task automatic wait_fetch(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (at_fetch_l()) begin
                ok = 1'b1;
                break;
            end
            cycle();
        end
    endtask

    task automatic compare_state();
        int bad;
        for (int i = 0; i < 4; i++) chk($sformatf("R%0d", i + 1), R[i], m_r[i]);
        chk("PC", PC, m_pc);
        chk("AR", AR, m_ar);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== m_mem[i]) bad++;
        chk("mem_diff_bytes", bad, 0);
    endtask

    task automatic run_prog(input int max_instr);
        bit ok, h;
        int cyc, cyc_exp, wr, wr_exp;
        wait_fetch(ok);
        chk("first_fetch", ok, 1);
        if (!ok) return;
        for (int k = 0; k < max_instr; k++) begin
            model_step(cyc_exp, wr_exp, h);
            cyc = 0; wr = 0;
            do begin
                if (!Mem_CS && Mem_WR) wr++;
                cycle();
                cyc++;
            end while (!at_fetch_l() && !Halted && cyc < 8);
            chk("latency", cyc, cyc_exp);
            chk("mem_wr_cycles", wr, wr_exp);
            chk("halted", Halted, h);
            if (h || cyc != cyc_exp) return;
            compare_state();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok, found;
        int bad;
        Reset = 1'b1; load_req = 1'b0;

        // LDI R1,#5A: three cycles after INIT, R1 loaded and PC = 2
        clear_prog(); put(0, 16'h005A); put(2, 16'hF000);
        do_reset();
        wait_fetch(ok);
        repeat (3) cycle();
        chk("ldi_r1", R[0], 8'h5A);
        chk("ldi_pc", PC, 8'h02);

        // ADD R1,R2 with 7F + 01
        clear_prog(); put(0, 16'h007F); put(2, 16'h0401); put(4, 16'h4100); put(6, 16'hF000);
        do_reset(); run_prog(10);
        chk("add_r1", R[0], 8'h80);

        // STM R2,0x20
        clear_prog(); put(0, 16'h0433); put(2, 16'h2420); put(4, 16'hF000);
        do_reset(); run_prog(10);
        chk("stm_mem20", mem[8'h20], 8'h33);

        // SUB R1,R1 then BEQ taken
        clear_prog(); put(0, 16'h005A); put(2, 16'h5000); put(4, 16'hC010); put(6, 16'hF000);
        put(16, 16'h08AA); put(18, 16'hF000);
        do_reset(); run_prog(10);
        chk("beq_r1", R[0], 8'h00);
        chk("beq_r3", R[2], 8'hAA);
        chk("beq_pc", PC, 8'h14);

        // Same with BNE: not taken, falls through to HALT at 6
        put(4, 16'hD010);
        do_reset(); run_prog(10);
        chk("bne_r3", R[2], 8'h00);
        chk("bne_pc", PC, 8'h08);

        // HALT holds for 20 cycles, then reset restarts from address 0
        clear_prog(); put(0, 16'hF000);
        do_reset(); run_prog(4);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (!Halted || !Mem_CS || Mem_WR) bad++;
            cycle();
        end
        chk("halt_hold", bad, 0);
        put(0, 16'h0011); put(2, 16'hF000);
        do_reset();
        wait_fetch(ok);
        chk("refetch_addr", arf_d, 8'h00);
        run_prog(4);
        chk("refetch_r1", R[0], 8'h11);

        // Reset asserted during STM EXEC2 suppresses the write
        clear_prog(); put(0, 16'h0433); put(2, 16'h2420); put(4, 16'hF000);
        prog[8'h20] = 8'h99;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (!Mem_CS && Mem_WR) found = 1'b1;
        end
        chk("stm_exec2_reached", found, 1);
        Reset = 1'b1;
        #1;
        chk("rst_mid_stm_wr", Mem_WR, 0);
        chk("rst_mid_stm_cs", Mem_CS, 1);
        @(negedge Clock);
        chk("rst_mid_stm_mem", mem[8'h20], 8'h99);
        Reset = 1'b0;
        #1;
        chk("rst_mid_stm_init", {RF_RSel, ARF_RegSel, IR_Enable}, {8'hFF, 1'b1});

        // Random programs (no explicit HALT opcode) against the reference model
        for (int p = 0; p < 6; p++) begin
            for (int a = 0; a < 256; a += 2)
                put(a, {4'($urandom_range(0, 14)), 12'($urandom)});
            do_reset();
            run_prog(60);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
